// File: rtl/key_token_fifo.sv
// Keypad event classifier and show-ahead token FIFO between the key scanner
// and the calculator; a clear key can optionally flush pending tokens.
module key_token_fifo #(
   parameter int unsigned DEPTH       = 4,
   parameter bit          CLEAR_FLUSH = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     key_flag,
   input  logic [3:0]               key_value,
   input  logic                     tok_ready,
   input  logic                     ovf_clr,
   output logic                     tok_valid,
   output logic [1:0]               tok_class,
   output logic [3:0]               tok_code,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

   typedef enum logic [1:0] {
      CLS_DIGIT  = 2'b00,
      CLS_OP     = 2'b01,
      CLS_EQUALS = 2'b10,
      CLS_CLEAR  = 2'b11
   } tok_class_t;

   logic [5:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ovf_q;

   tok_class_t    new_class;
   logic [3:0]    new_code;
   logic [5:0]    head;
   logic          full;
   logic          pop_req;
   logic          do_push;
   logic          drop;
   logic          flush_now;

   // Classify before storage so each entry only carries class + code.
   always_comb begin
      new_class = CLS_DIGIT;
      new_code  = '0;
      if (key_value <= 4'd9) begin
         new_class = CLS_DIGIT;
         new_code  = key_value;
      end else if (key_value <= 4'd13) begin
         new_class = CLS_OP;
         new_code  = key_value - 4'd10;
      end else if (key_value == 4'd14) begin
         new_class = CLS_EQUALS;
         new_code  = '0;
      end else begin
         new_class = CLS_CLEAR;
         new_code  = '0;
      end
   end

   always_comb begin
      full      = (count == FULL_COUNT);
      pop_req   = tok_valid && tok_ready;
      flush_now = CLEAR_FLUSH && key_flag && (new_class == CLS_CLEAR);
      do_push   = key_flag && (!full || pop_req);
      drop      = key_flag && full && !pop_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else if (flush_now) begin
         // Flush: head jumps to the slot receiving the clear token; any pop is ignored.
         mem[wr_ptr] <= {CLS_CLEAR, 4'd0};
         rd_ptr      <= wr_ptr;
         wr_ptr      <= wr_ptr + 1'b1;
         count       <= ONE_COUNT;
         if (ovf_clr)
            ovf_q <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= {new_class, new_code};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_req)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop_req})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)
            ovf_q <= 1'b1;
         else if (ovf_clr)
            ovf_q <= 1'b0;
      end
   end

   always_comb begin
      head       = mem[rd_ptr];
      tok_valid  = (count != '0);
      tok_class  = '0;
      tok_code   = '0;
      if (tok_valid) begin
         tok_class = head[5:4];
         tok_code  = head[3:0];
      end
      fifo_count = count;
      overflow   = ovf_q;
   end

endmodule
